cdb_arbiter: RTL and testbench

//  Parametrised common-data-bus arbiter for the out-of-order core. Collects

---
 rtl/cdb_arbiter.sv | 75 +++++++
 tb/tb_cdb_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: picks one execution-unit result per cycle
// (round-robin or fixed priority) and broadcasts it through a register.
module cdb_arbiter #(
  parameter int N_UNITS  = 4,
  parameter int RSV_ID_W = 6,
  parameter int DATA_W   = 32,
  parameter int CDB_W    = RSV_ID_W + DATA_W,
  parameter bit RR_MODE  = 1'b1,
  localparam int UW      = (N_UNITS > 1) ? $clog2(N_UNITS) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     branch_miss,
  input  logic [N_UNITS*CDB_W-1:0] i_cdb,
  input  logic [N_UNITS-1:0]       i_valid,
  output logic [N_UNITS-1:0]       i_ready,
  output logic [CDB_W-1:0]         cdb,
  output logic                     cdb_valid,
  output logic [UW-1:0]            cdb_unit
);

  logic [CDB_W-1:0]   pkt [N_UNITS];
  logic [UW-1:0]      ptr;
  logic [UW-1:0]      gnt;
  logic [UW-1:0]      gnt_nxt;
  logic               any;
  logic [N_UNITS-1:0] ready;

  for (genvar u = 0; u < N_UNITS; u++) begin : g_pkt
    assign pkt[u] = i_cdb[u*CDB_W +: CDB_W];
  end

  // Scan starts at ptr in RR mode, at unit 0 in fixed-priority mode.
  always_comb begin : sel
    int idx;
    idx   = 0;
    ready = '0;
    gnt   = '0;
    any   = 1'b0;
    if (!rst && !branch_miss) begin
      for (int k = 0; k < N_UNITS; k++) begin
        if (RR_MODE) idx = (int'(ptr) + k) % N_UNITS;
        else         idx = k;
        if (!any && i_valid[idx]) begin
          any        = 1'b1;
          ready[idx] = 1'b1;
          gnt        = UW'(idx);
        end
      end
    end
  end

  assign i_ready = ready;

  always_comb begin
    gnt_nxt = gnt + UW'(1);
    if (int'(gnt) == N_UNITS - 1) gnt_nxt = '0;
  end

  // Bus is zeroed whenever nothing was granted, so no stale tag lingers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cdb       <= '0;
      cdb_valid <= 1'b0;
      cdb_unit  <= '0;
      ptr       <= '0;
    end else begin
      cdb_valid <= any;
      cdb       <= any ? pkt[gnt] : '0;
      cdb_unit  <= any ? gnt : '0;
      if (RR_MODE && any) ptr <= gnt_nxt;
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed scenarios plus
// randomized traffic against a queue-based reference model.
module tb_cdb_arbiter;

  localparam int N  = 4;
  localparam int RW = 6;
  localparam int DW = 16;
  localparam int CW = RW + DW;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            branch_miss = 1'b0;
  logic [N*CW-1:0] i_cdb = '0;
  logic [N-1:0]    i_valid = '0;

  logic [N-1:0]    rdy_rr, rdy_fp;
  logic [CW-1:0]   cdb_rr, cdb_fp;
  logic            val_rr, val_fp;
  logic [1:0]      unit_rr, unit_fp;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cdb_arbiter #(.N_UNITS(N), .RSV_ID_W(RW), .DATA_W(DW), .RR_MODE(1'b1)) u_rr (
    .clk(clk), .rst(rst), .branch_miss(branch_miss), .i_cdb(i_cdb),
    .i_valid(i_valid), .i_ready(rdy_rr), .cdb(cdb_rr),
    .cdb_valid(val_rr), .cdb_unit(unit_rr)
  );

  cdb_arbiter #(.N_UNITS(N), .RSV_ID_W(RW), .DATA_W(DW), .RR_MODE(1'b0)) u_fp (
    .clk(clk), .rst(rst), .branch_miss(branch_miss), .i_cdb(i_cdb),
    .i_valid(i_valid), .i_ready(rdy_fp), .cdb(cdb_fp),
    .cdb_valid(val_fp), .cdb_unit(unit_fp)
  );

  function automatic logic [CW-1:0] mk(input int id, input int data);
    return {RW'(id), DW'(data)};
  endfunction

  task automatic set_pkt(input int u, input logic [CW-1:0] p);
    i_cdb[u*CW +: CW] = p;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    branch_miss = 1'b0;
    i_valid = '0;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  task automatic load_default();
    for (int u = 0; u < N; u++) set_pkt(u, mk(u, 16'hA000 + u));
  endtask

  task automatic test_reset();
    load_default();
    rst = 1'b1;
    i_valid = '1;
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++;
      if (rdy_rr !== 4'b0 || rdy_fp !== 4'b0) begin
        errors++;
        $display("FAIL reset_ready: got %b/%b need 0000", rdy_rr, rdy_fp);
      end
      tick();
      checks++;
      if (val_rr !== 1'b0 || cdb_rr !== '0 || unit_rr !== 2'd0) begin
        errors++;
        $display("FAIL reset_out: got v=%b cdb=%h u=%0d need 0", val_rr, cdb_rr, unit_rr);
      end
    end
    rst = 1'b0;
    #1;
    checks++;
    if (rdy_rr !== 4'b0001) begin
      errors++;
      $display("FAIL reset_first_grant: got %b need 0001", rdy_rr);
    end
    tick();
    checks++;
    if (val_rr !== 1'b1 || unit_rr !== 2'd0 || cdb_rr !== mk(0, 16'hA000)) begin
      errors++;
      $display("FAIL reset_first_out: got v=%b u=%0d cdb=%h need 1/0/%h", val_rr, unit_rr, cdb_rr, mk(0, 16'hA000));
    end
  endtask

  task automatic test_rr_fairness();
    do_reset();
    load_default();
    i_valid = '1;
    for (int k = 0; k < 8; k++) begin
      #1;
      checks++;
      if (rdy_rr !== 4'(1 << (k % N))) begin
        errors++;
        $display("FAIL rr_ready[%0d]: got %b need %b", k, rdy_rr, 4'(1 << (k % N)));
      end
      checks++;
      if (rdy_fp !== 4'b0001) begin
        errors++;
        $display("FAIL fp_all_ready[%0d]: got %b need 0001", k, rdy_fp);
      end
      tick();
      checks++;
      if (val_rr !== 1'b1 || unit_rr !== 2'(k % N) || cdb_rr !== mk(k % N, 16'hA000 + k % N)) begin
        errors++;
        $display("FAIL rr_seq[%0d]: got v=%b u=%0d need 1/%0d", k, val_rr, unit_rr, k % N);
      end
    end
    i_valid = '0;
  endtask

  task automatic test_fixed();
    do_reset();
    load_default();
    i_valid = 4'b1010;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (rdy_fp !== 4'b0010) begin
        errors++;
        $display("FAIL fp_ready[%0d]: got %b need 0010", k, rdy_fp);
      end
      tick();
      checks++;
      if (val_fp !== 1'b1 || unit_fp !== 2'd1 || cdb_fp !== mk(1, 16'hA001)) begin
        errors++;
        $display("FAIL fp_out[%0d]: got v=%b u=%0d need 1/1", k, val_fp, unit_fp);
      end
    end
    i_valid = '0;
  endtask

  task automatic test_flush();
    do_reset();
    load_default();
    set_pkt(2, mk(5, 16'h1234));
    i_valid = 4'b0100;
    #1;
    checks++;
    if (rdy_rr !== 4'b0100) begin
      errors++;
      $display("FAIL flush_grant: got %b need 0100", rdy_rr);
    end
    tick();
    branch_miss = 1'b1;
    i_valid = 4'b1011;
    #1;
    checks++;
    if (val_rr !== 1'b1 || cdb_rr !== mk(5, 16'h1234) || unit_rr !== 2'd2) begin
      errors++;
      $display("FAIL flush_t1_out: got v=%b cdb=%h need 1/%h", val_rr, cdb_rr, mk(5, 16'h1234));
    end
    checks++;
    if (rdy_rr !== 4'b0 || rdy_fp !== 4'b0) begin
      errors++;
      $display("FAIL flush_ready: got %b/%b need 0000", rdy_rr, rdy_fp);
    end
    tick();
    branch_miss = 1'b0;
    checks++;
    if (val_rr !== 1'b0 || cdb_rr !== '0) begin
      errors++;
      $display("FAIL flush_t2_out: got v=%b cdb=%h need 0/0", val_rr, cdb_rr);
    end
    i_valid = '1;
    #1;
    checks++;
    if (rdy_rr !== 4'b1000) begin
      errors++;
      $display("FAIL flush_ptr_hold: got %b need 1000", rdy_rr);
    end
    tick();
    i_valid = '0;
  endtask

  task automatic test_wrap_idle();
    do_reset();
    load_default();
    i_valid = 4'b1000;
    #1;
    checks++;
    if (rdy_rr !== 4'b1000) begin
      errors++;
      $display("FAIL wrap_grant3: got %b need 1000", rdy_rr);
    end
    tick();
    i_valid = '0;
    checks++;
    if (val_rr !== 1'b1 || unit_rr !== 2'd3) begin
      errors++;
      $display("FAIL wrap_out3: got v=%b u=%0d need 1/3", val_rr, unit_rr);
    end
    tick();
    checks++;
    if (val_rr !== 1'b0 || cdb_rr !== '0 || unit_rr !== 2'd0) begin
      errors++;
      $display("FAIL wrap_idle: got v=%b cdb=%h need 0/0", val_rr, cdb_rr);
    end
    i_valid = 4'b1001;
    #1;
    checks++;
    if (rdy_rr !== 4'b0001) begin
      errors++;
      $display("FAIL wrap_grant0: got %b need 0001", rdy_rr);
    end
    tick();
    checks++;
    if (val_rr !== 1'b1 || unit_rr !== 2'd0 || cdb_rr !== mk(0, 16'hA000)) begin
      errors++;
      $display("FAIL wrap_out0: got v=%b u=%0d need 1/0", val_rr, unit_rr);
    end
    i_valid = '0;
  endtask

  // Reference: first valid unit in rotation order starting from 'start'.
  function automatic int pick(input logic [N-1:0] v, input int start);
    for (int k = 0; k < N; k++)
      if (v[(start + k) % N]) return (start + k) % N;
    return -1;
  endfunction

  task automatic test_random();
    logic [CW-1:0] sb [$];
    logic [CW-1:0] cur [N];
    logic [N-1:0]  took;
    logic [CW-1:0] exp_pkt, head;
    int ptr, g_rr, g_fp, shown, age [N];
    do_reset();
    ptr = 0;
    took = '0;
    shown = 0;
    for (int u = 0; u < N; u++) age[u] = 0;
    for (int c = 0; c < 10000; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      branch_miss = ($urandom_range(0, 9) == 0);
      for (int u = 0; u < N; u++) begin
        if (!i_valid[u] || took[u]) begin
          i_valid[u] = ($urandom_range(0, 2) != 0);
          cur[u] = CW'($urandom);
          set_pkt(u, cur[u]);
          age[u] = 0;
        end
      end
      #1;
      g_rr = (rst || branch_miss) ? -1 : pick(i_valid, ptr);
      g_fp = (rst || branch_miss) ? -1 : pick(i_valid, 0);
      checks++;
      if (rdy_rr !== ((g_rr < 0) ? 4'b0 : 4'(1 << g_rr)) || !$onehot0(rdy_rr)) begin
        errors++;
        if (shown++ < 20) $display("FAIL rnd_rr_ready c=%0d: got %b need grant %0d", c, rdy_rr, g_rr);
      end
      checks++;
      if (rdy_fp !== ((g_fp < 0) ? 4'b0 : 4'(1 << g_fp))) begin
        errors++;
        if (shown++ < 20) $display("FAIL rnd_fp_ready c=%0d: got %b need grant %0d", c, rdy_fp, g_fp);
      end
      took = rdy_rr;
      if (g_rr >= 0) sb.push_back(cur[g_rr]);
      exp_pkt = (g_fp >= 0) ? cur[g_fp] : '0;
      tick();
      if (rst) ptr = 0;
      else if (g_rr >= 0) ptr = (g_rr + 1) % N;
      for (int u = 0; u < N; u++) begin
        if (i_valid[u] && !took[u]) age[u]++;
        checks++;
        if (age[u] > N) begin
          errors++;
          if (shown++ < 20) $display("FAIL rnd_starve c=%0d unit %0d: waited %0d need <=%0d", c, u, age[u], N);
        end
        if (branch_miss || rst) age[u] = 0;
      end
      checks++;
      if (val_rr !== (g_rr >= 0) || unit_rr !== 2'((g_rr < 0) ? 0 : g_rr)) begin
        errors++;
        if (shown++ < 20) $display("FAIL rnd_rr_out c=%0d: got v=%b u=%0d need grant %0d", c, val_rr, unit_rr, g_rr);
      end
      if (val_rr === 1'b1 && sb.size() > 0) begin
        head = sb.pop_front();
        checks++;
        if (cdb_rr !== head) begin
          errors++;
          if (shown++ < 20) $display("FAIL rnd_sb c=%0d: got %h need %h", c, cdb_rr, head);
        end
      end else if (val_rr !== 1'b1) begin
        checks++;
        if (cdb_rr !== '0) begin
          errors++;
          if (shown++ < 20) $display("FAIL rnd_idle_bus c=%0d: got %h need 0", c, cdb_rr);
        end
      end
      checks++;
      if (val_fp !== (g_fp >= 0) || cdb_fp !== exp_pkt) begin
        errors++;
        if (shown++ < 20) $display("FAIL rnd_fp_out c=%0d: got v=%b cdb=%h need %h", c, val_fp, cdb_fp, exp_pkt);
      end
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL rnd_sb_drain: got %0d left need 0", sb.size());
    end
    rst = 1'b0;
    branch_miss = 1'b0;
    i_valid = '0;
  endtask

  initial begin
    test_reset();
    test_rr_fairness();
    test_fixed();
    test_flush();
    test_wrap_idle();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
